// File: rtl/player_ctrl_pkg.sv
// Shared game constants: screen geometry, sprite size and the transparent colour key.
// Also holds the procedural sprite image that player_rom serves.
package player_ctrl_pkg;

    localparam int GAME_SCREEN_W = 640;
    localparam int GAME_SCREEN_H = 480;
    localparam int GAME_SPRITE   = 32;

    localparam int ROM_AW = 10;
    localparam int RGB_W  = 12;

    localparam logic [RGB_W-1:0] TRANSPARENT = 12'hF0F;

    // 32x32 ship image: a two-pixel transparent margin on the top and left edges,
    // opaque body coloured by row/column so every address reads back distinctly.
    function automatic logic [RGB_W-1:0] sprite_pixel(input logic [ROM_AW-1:0] addr);
        logic [4:0] row;
        logic [4:0] col;
        row = addr[9:5];
        col = addr[4:0];
        if (row < 5'd2 || col < 5'd2) begin
            return TRANSPARENT;
        end
        return {row[3:0], col[3:0], 4'hA};
    endfunction

endpackage

// File: rtl/player_rom.sv
// 1024x12 player sprite ROM with a registered read port (one clock of latency).
module player_rom
    import player_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] addr,
    output logic [RGB_W-1:0]  data
);

    logic [RGB_W-1:0] data_d;
    logic [RGB_W-1:0] data_q;

    always_comb begin
        data_d = sprite_pixel(addr);
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/player_ctrl.sv
// Player ship: per-frame keyboard movement with edge clamping, collision respawn with
// blinking invulnerability, and sprite pixel lookup for the VGA scan position.
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int SCREEN_W      = GAME_SCREEN_W,
    parameter int SCREEN_H      = GAME_SCREEN_H,
    parameter int SPRITE        = GAME_SPRITE,
    parameter int START_X       = 304,
    parameter int START_Y       = 400,
    parameter int SPEED         = 4,
    parameter int SLOW_SPEED    = 1,
    parameter int INVULN_FRAMES = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             game_en,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_left,
    input  logic             key_right,
    input  logic             key_focus,
    input  logic             collision,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    output logic [9:0]       player_x,
    output logic [9:0]       player_y,
    output logic             player_on,
    output logic [RGB_W-1:0] player_rgb,
    output logic             invuln
);

    localparam int CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    localparam logic [9:0]         SCREEN_H10 = 10'(SCREEN_H);
    localparam logic [9:0]         SPRITE10   = 10'(SPRITE);
    localparam logic [10:0]        SPRITE11   = 11'(SPRITE);
    localparam logic signed [10:0] MAX_X      = 11'(SCREEN_W - SPRITE);
    localparam logic signed [10:0] MAX_Y      = 11'(SCREEN_H - SPRITE);
    localparam logic signed [10:0] SPEED11    = 11'(SPEED);
    localparam logic signed [10:0] SLOW11     = 11'(SLOW_SPEED);

    logic [9:0]       pos_x_q, pos_x_d;
    logic [9:0]       pos_y_q, pos_y_d;
    logic [CNT_W-1:0] inv_cnt_q, inv_cnt_d;
    logic [3:0]       frame_cnt_q, frame_cnt_d;
    logic             at_bottom_q, at_bottom_d;
    logic             in_box_q, in_box_d;

    logic              frame_tick;
    logic              hit;
    logic              advance;
    logic signed [10:0] speed;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [9:0]        row_off;
    logic [9:0]        col_off;
    logic [ROM_AW-1:0] rom_addr;
    logic [RGB_W-1:0]  rom_data;
    logic              blank;

    function automatic logic [9:0] clamp_add(input logic [9:0] pos,
                                             input logic signed [10:0] delta,
                                             input logic signed [10:0] max_pos);
        logic signed [10:0] sum;
        sum = $signed({1'b0, pos}) + delta;
        if (sum < 11'sd0) begin
            return 10'd0;
        end
        if (sum > max_pos) begin
            return max_pos[9:0];
        end
        return sum[9:0];
    endfunction

    always_comb begin
        frame_tick = (y == SCREEN_H10) && !at_bottom_q;
        advance    = game_en && frame_tick;
        hit        = game_en && collision && (inv_cnt_q == '0);
        speed      = key_focus ? SLOW11 : SPEED11;

        dx = '0;
        if (key_right && !key_left) begin
            dx = speed;
        end else if (key_left && !key_right) begin
            dx = -speed;
        end

        dy = '0;
        if (key_down && !key_up) begin
            dy = speed;
        end else if (key_up && !key_down) begin
            dy = -speed;
        end

        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        inv_cnt_d   = inv_cnt_q;
        frame_cnt_d = frame_cnt_q;
        at_bottom_d = (y == SCREEN_H10);

        // A hit on the same cycle as a frame tick respawns without moving.
        if (hit) begin
            pos_x_d   = 10'(START_X);
            pos_y_d   = 10'(START_Y);
            inv_cnt_d = CNT_W'(INVULN_FRAMES);
        end else if (advance) begin
            pos_x_d = clamp_add(pos_x_q, dx, MAX_X);
            pos_y_d = clamp_add(pos_y_q, dy, MAX_Y);
            if (inv_cnt_q != '0) begin
                inv_cnt_d = inv_cnt_q - CNT_W'(1);
            end
        end

        if (advance) begin
            frame_cnt_d = frame_cnt_q + 4'd1;
        end

        col_off  = x - pos_x_q;
        row_off  = y - pos_y_q;
        in_box_d = ({1'b0, x} >= {1'b0, pos_x_q}) && ({1'b0, x} < ({1'b0, pos_x_q} + SPRITE11)) &&
                   ({1'b0, y} >= {1'b0, pos_y_q}) && ({1'b0, y} < ({1'b0, pos_y_q} + SPRITE11));
        rom_addr = row_off * SPRITE10 + col_off;
    end

    // The y-edge tracker keeps following the scan through reset so no tick appears on release.
    always_ff @(posedge clk) begin
        at_bottom_q <= at_bottom_d;
        if (reset) begin
            pos_x_q     <= 10'(START_X);
            pos_y_q     <= 10'(START_Y);
            inv_cnt_q   <= '0;
            frame_cnt_q <= '0;
            in_box_q    <= 1'b0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            inv_cnt_q   <= inv_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            in_box_q    <= in_box_d;
        end
    end

    player_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    assign invuln     = (inv_cnt_q != '0);
    assign blank      = invuln && frame_cnt_q[3];
    assign player_on  = in_box_q && (rom_data != TRANSPARENT) && !blank;
    assign player_rgb = player_on ? rom_data : 12'h000;
    assign player_x   = pos_x_q;
    assign player_y   = pos_y_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed scoreboard bench for player_ctrl: movement, clamping, respawn/invulnerability,
// blink, sprite pixel latency and reset priority.
module tb_player_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        game_en;
    logic        key_up, key_down, key_left, key_right, key_focus;
    logic        collision;
    logic [9:0]  x, y;
    logic [9:0]  player_x, player_y;
    logic        player_on;
    logic [11:0] player_rgb;
    logic        invuln;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    int m_x, m_y, m_cnt, m_frame;

    player_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .game_en    (game_en),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_focus  (key_focus),
        .collision  (collision),
        .x          (x),
        .y          (y),
        .player_x   (player_x),
        .player_y   (player_y),
        .player_on  (player_on),
        .player_rgb (player_rgb),
        .invuln     (invuln)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input int sel, input logic [31:0] e);
        sb_t item;
        item.tag = tag;
        item.sel = sel;
        item.exp = e;
        sb_q.push_back(item);
    endtask

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            0:       return {22'd0, player_x};
            1:       return {22'd0, player_y};
            2:       return {31'd0, invuln};
            3:       return {31'd0, player_on};
            default: return {20'd0, player_rgb};
        endcase
    endfunction

    task automatic checkOutput();
        sb_t         item;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            obs  = observed(item.sel);
            compared++;
            assert (obs === item.exp) else begin
                mismatched++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic expect_state(input string tag);
        push_exp({tag, "_x"}, 0, 32'(m_x));
        push_exp({tag, "_y"}, 1, 32'(m_y));
        push_exp({tag, "_inv"}, 2, {31'd0, m_cnt != 0});
    endtask

    function automatic int clamp(input int v, input int lim);
        if (v < 0) return 0;
        if (v > lim) return lim;
        return v;
    endfunction

    task automatic do_frame();
        int sp;
        y = 10'd480;
        step();
        if (game_en) begin
            m_frame++;
            if (collision && m_cnt == 0) begin
                m_x   = 304;
                m_y   = 400;
                m_cnt = 120;
            end else begin
                sp  = key_focus ? 1 : 4;
                m_x = clamp(m_x + (key_right ? sp : 0) - (key_left ? sp : 0), 608);
                m_y = clamp(m_y + (key_down ? sp : 0) - (key_up ? sp : 0), 448);
                if (m_cnt > 0) m_cnt--;
            end
        end
        y = 10'd0;
        step();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    task automatic pulse_collision();
        collision = 1'b1;
        step();
        if (game_en && m_cnt == 0) begin
            m_x   = 304;
            m_y   = 400;
            m_cnt = 120;
        end
        collision = 1'b0;
    endtask

    // Drives a scan position, confirms the output is still idle before the clock, then
    // expects the pixel result one clock later.
    task automatic applyStimulus(input string tag, input int xv, input int yv,
                                 input logic exp_on, input logic [11:0] exp_rgb);
        x = 10'(xv);
        y = 10'(yv);
        push_exp({tag, "_pre"}, 3, 32'd0);
        checkOutput();
        push_exp({tag, "_on"}, 3, {31'd0, exp_on});
        push_exp({tag, "_rgb"}, 4, {20'd0, exp_rgb});
        step();
        checkOutput();
        x = 10'd0;
        y = 10'd0;
        step();
    endtask

    task automatic clear_keys();
        key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_focus = 0;
    endtask

    initial begin
        reset = 1; game_en = 1; collision = 0; x = 0; y = 0;
        clear_keys();
        step();
        step();
        reset = 0;
        m_x = 304; m_y = 400; m_cnt = 0; m_frame = 0;
        expect_state("reset");
        push_exp("reset_on", 3, 32'd0);
        push_exp("reset_rgb", 4, 32'd0);
        checkOutput();

        key_right = 1;
        frames(10);
        clear_keys();
        push_exp("right10_x", 0, 32'd344);
        expect_state("right10");
        checkOutput();

        key_left = 1;
        frames(85);
        push_exp("left85_x", 0, 32'd4);
        checkOutput();
        key_focus = 1;
        frames(3);
        push_exp("focus3_x", 0, 32'd1);
        checkOutput();
        frames(7);
        clear_keys();
        push_exp("focus10_x", 0, 32'd0);
        expect_state("focus10");
        checkOutput();

        key_left = 1; key_right = 1; key_up = 1; key_down = 1;
        frames(5);
        clear_keys();
        push_exp("allkeys_x", 0, 32'd0);
        push_exp("allkeys_y", 1, 32'd400);
        checkOutput();

        key_down = 1;
        frames(15);
        clear_keys();
        push_exp("down_clamp_y", 1, 32'd448);
        checkOutput();

        key_right = 1;
        frames(125);
        clear_keys();
        key_up = 1;
        frames(87);
        clear_keys();
        push_exp("pre_hit_x", 0, 32'd500);
        push_exp("pre_hit_y", 1, 32'd100);
        checkOutput();

        pulse_collision();
        push_exp("hit_x", 0, 32'd304);
        push_exp("hit_y", 1, 32'd400);
        push_exp("hit_inv", 2, 32'd1);
        checkOutput();
        frames(50);
        pulse_collision();
        expect_state("hit2_ignored");
        push_exp("hit2_inv", 2, 32'd1);
        checkOutput();
        frames(69);
        push_exp("inv119_inv", 2, 32'd1);
        checkOutput();
        frames(1);
        push_exp("inv120_inv", 2, 32'd0);
        expect_state("inv_done");
        checkOutput();

        key_right = 1;
        frames(5);
        push_exp("pre_tickhit_x", 0, 32'd324);
        checkOutput();
        key_right = 0;
        key_up    = 1;
        collision = 1;
        y         = 10'd480;
        step();
        m_frame++;
        m_x = 304; m_y = 400; m_cnt = 120;
        collision = 0;
        key_up    = 0;
        y         = 10'd0;
        step();
        push_exp("tickhit_x", 0, 32'd304);
        push_exp("tickhit_y", 1, 32'd400);
        push_exp("tickhit_inv", 2, 32'd1);
        checkOutput();

        while ((m_frame & 8) == 0) do_frame();
        applyStimulus("blink", 309, 406, 1'b0, 12'h000);
        while ((m_frame & 8) != 0) do_frame();
        expect_state("visible");
        checkOutput();
        applyStimulus("opaque", 309, 406, 1'b1, 12'h65A);
        applyStimulus("transparent", 304, 400, 1'b0, 12'h000);
        applyStimulus("corner", 335, 431, 1'b1, 12'hFFA);
        applyStimulus("outside", 336, 400, 1'b0, 12'h000);

        game_en   = 0;
        key_right = 1;
        frames(5);
        expect_state("frozen");
        checkOutput();
        game_en = 1;

        reset     = 1;
        collision = 1;
        y         = 10'd480;
        step();
        m_x = 304; m_y = 400; m_cnt = 0; m_frame = 0;
        reset     = 0;
        collision = 0;
        expect_state("reset_prio");
        checkOutput();
        step();
        step();
        push_exp("no_tick_after_reset_x", 0, 32'd304);
        checkOutput();
        y = 10'd0;
        step();
        do_frame();
        key_right = 0;
        push_exp("first_tick_x", 0, 32'd308);
        expect_state("first_tick");
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
